retire_unit: RTL and testbench
==============================

RETIRE_UNIT -- requirements
Module: retire_unit

Interface
REQ-001 Parameter ARCH_REGS, default 64: architectural register count; AR = $clog2(ARCH_REGS).
REQ-002 Parameter PHYS_REGS, default 128: physical register count; PR = $clog2(PHYS_REGS).
REQ-003 Parameter COMMIT_WIDTH, default 2: W, number of ROB head slots examined per cycle.
REQ-004 Parameter FLUSH_CYCLES, default 2, legal range 1-15: number of cycles retirement is blocked after a mispredict.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 rob_valid_i  in  W  head slot i holds an instruction; slot 0 is oldest.
REQ-008 rob_complete_i  in  W  slot i has finished execution.
REQ-009 rob_has_dest_i  in  W  slot i writes a destination register.
REQ-010 rob_mispred_i  in  W  slot i is a mispredicted branch.
REQ-011 rob_arch_i  in  W x AR  destination architectural register.
REQ-012 rob_new_phys_i  in  W x PR  newly mapped physical register.
REQ-013 rob_old_phys_i  in  W x PR  previous mapping, freed at retire.
REQ-014 rob_target_i  in  W x 32  correct PC of slot i when mispredicted.
REQ-015 retire_o  in-slot mask  out  W  combinational; slot i leaves the ROB at this clock edge.
REQ-016 commit_valid_o / commit_arch_o / commit_phys_o  out  W / W x AR / W x PR  registered map-table commit port.
REQ-017 free_valid_o / free_phys_o  out  W / W x PR  registered free-list return port.
REQ-018 flush_o  out  1  registered one-cycle pipeline flush pulse.
REQ-019 redirect_pc_o  out  32  fetch redirect target; valid only while flush_o=1.
REQ-020 retired_count_o / mispred_count_o  out  32 / 32  statistics counters.

Function
REQ-021 FSM states are RUN and FLUSH; retire_o is forced to 0 in FLUSH.
REQ-022 In RUN, retire_o[i]=1 only if rob_valid_i[i]=1, rob_complete_i[i]=1, retire_o[j]=1 for all j<i, and rob_mispred_i[j]=0 for all j<i (prefix rule; no holes).
REQ-023 A mispredicted slot itself retires; every younger slot in the same cycle is blocked.
REQ-024 Each slot retired at edge t with rob_has_dest_i=1 and rob_arch_i!=0 drives, during cycle t+1, commit_valid_o[i]=1 with rob_arch_i/rob_new_phys_i, and free_valid_o[i]=1 with rob_old_phys_i.
REQ-025 Slots that are not retired, have rob_has_dest_i=0, or have arch 0 drive commit_valid_o[i]=0 and free_valid_o[i]=0 in t+1; the data fields are don't-care.
REQ-026 Output slot order equals ROB slot order, so the downstream map table resolves same-register writes in the same cycle by taking the higher slot index.
REQ-027 A mispredicted slot retired at edge t drives flush_o=1 and redirect_pc_o=rob_target_i of that slot in t+1; the FSM enters FLUSH at edge t.
REQ-028 FLUSH lasts exactly FLUSH_CYCLES cycles, counted from t+1, and then returns to RUN; flush_o stays 0 after the first FLUSH cycle.
REQ-029 The commit and free outputs of the mispredicted instruction are still produced in t+1.
REQ-030 All registered outputs are 0 in any cycle that follows an edge with no retirement.

Reset
REQ-031 On reset, the FSM enters RUN, and all of the following are 0 on the next cycle: commit_valid_o, free_valid_o, flush_o, redirect_pc_o, the counters, and the flush-cycle counter.
REQ-032 Reset asserted during FLUSH aborts the flush immediately; reset has priority over every other event.

Configuration
REQ-033 Macro RETIRE_UNIT_STATS_EN defined: retired_count_o increments by popcount(retire_o) each edge, mispred_count_o increments by 1 per mispredict retire, and both counters wrap modulo 2^32.
REQ-034 Macro RETIRE_UNIT_STATS_EN undefined: no counter flops are built, and retired_count_o and mispred_count_o are tied to 0.

Verification
REQ-035 Both slots valid, complete, has_dest, arch 5/7, new 70/71, old 5/7 -> retire_o=11; next cycle commit_valid_o=11, arch 5/7, phys 70/71; free_valid_o=11, phys 5/7.
REQ-036 Slot0 valid but incomplete, slot1 complete -> retire_o=00; next cycle commit_valid_o=00 and free_valid_o=00.
REQ-037 Slot0 mispred, complete, target 0x1000, with slot1 complete -> retire_o=01; next cycle flush_o=1 and redirect_pc_o=0x1000; with FLUSH_CYCLES=2, retire_o=0 for 2 cycles, then retirement resumes.
REQ-038 Both slots retire, with arch 3 in each slot and new 40/41 -> next cycle commit_valid_o=11 with slot1 carrying phys 41; arch 0 slot -> commit and free bits are 0 in that slot.
REQ-039 Reset asserted in the first FLUSH cycle -> the next cycle is in RUN with retire_o following REQ-022 and flush_o=0.
REQ-040 With STATS_EN, 3 cycles of 2 retires plus 1 mispredict -> retired_count_o=6, mispred_count_o=1; without STATS_EN -> both read 0.

Source files
------------

// File: rtl/retire_unit.sv
`default_nettype none
// ============================================================================
// Module   : retire_unit
// Purpose  : In-order ROB retirement with a map-table commit port, a free-list
//            return port, and a mispredict flush/redirect sequence.
// Options  : RETIRE_UNIT_STATS_EN builds the retired/mispredict counters.
// Revision : 1.0 - initial release
// ============================================================================
module retire_unit #(
   parameter int ARCH_REGS    = 64,
   parameter int PHYS_REGS    = 128,
   parameter int COMMIT_WIDTH = 2,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                                                clock,
   input  logic                                                reset,
   input  logic [COMMIT_WIDTH-1:0]                             rob_valid_i,
   input  logic [COMMIT_WIDTH-1:0]                             rob_complete_i,
   input  logic [COMMIT_WIDTH-1:0]                             rob_has_dest_i,
   input  logic [COMMIT_WIDTH-1:0]                             rob_mispred_i,
   input  logic [COMMIT_WIDTH-1:0][$clog2(ARCH_REGS)-1:0]      rob_arch_i,
   input  logic [COMMIT_WIDTH-1:0][$clog2(PHYS_REGS)-1:0]      rob_new_phys_i,
   input  logic [COMMIT_WIDTH-1:0][$clog2(PHYS_REGS)-1:0]      rob_old_phys_i,
   input  logic [COMMIT_WIDTH-1:0][31:0]                       rob_target_i,
   output logic [COMMIT_WIDTH-1:0]                             retire_o,
   output logic [COMMIT_WIDTH-1:0]                             commit_valid_o,
   output logic [COMMIT_WIDTH-1:0][$clog2(ARCH_REGS)-1:0]      commit_arch_o,
   output logic [COMMIT_WIDTH-1:0][$clog2(PHYS_REGS)-1:0]      commit_phys_o,
   output logic [COMMIT_WIDTH-1:0]                             free_valid_o,
   output logic [COMMIT_WIDTH-1:0][$clog2(PHYS_REGS)-1:0]      free_phys_o,
   output logic                                                flush_o,
   output logic [31:0]                                         redirect_pc_o,
   output logic [31:0]                                         retired_count_o,
   output logic [31:0]                                         mispred_count_o
);

   localparam int AR = $clog2(ARCH_REGS);
   localparam int PR = $clog2(PHYS_REGS);
   localparam logic [3:0] c_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   typedef enum logic [0:0] {
      S_RUN   = 1'b0,
      S_FLUSH = 1'b1
   } state_t;

   state_t                          r_state;
   state_t                          w_state_nxt;
   logic [3:0]                      r_flush_cnt;
   logic [3:0]                      w_flush_cnt_nxt;

   logic [COMMIT_WIDTH-1:0]         w_retire;
   logic [COMMIT_WIDTH-1:0]         w_commit;
   logic                            w_mispred;
   logic [31:0]                     w_redirect;
   logic [COMMIT_WIDTH-1:0][AR-1:0] w_commit_arch;
   logic [COMMIT_WIDTH-1:0][PR-1:0] w_commit_phys;
   logic [COMMIT_WIDTH-1:0][PR-1:0] w_free_phys;

   // Prefix rule: a slot retires only if every older slot retired and none
   // of them was a mispredicted branch.
   always_comb begin : b_retire
      logic v_ok;
      w_retire = '0;
      v_ok     = (r_state == S_RUN);
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         w_retire[i] = v_ok & rob_valid_i[i] & rob_complete_i[i];
         v_ok        = w_retire[i] & ~rob_mispred_i[i];
      end
   end

   assign retire_o = w_retire;

   always_comb begin
      w_mispred     = 1'b0;
      w_redirect    = '0;
      w_commit      = '0;
      w_commit_arch = '0;
      w_commit_phys = '0;
      w_free_phys   = '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         if (w_retire[i] && rob_mispred_i[i]) begin
            w_mispred  = 1'b1;
            w_redirect = rob_target_i[i];
         end
         w_commit[i] = w_retire[i] & rob_has_dest_i[i] & (rob_arch_i[i] != '0);
         if (w_commit[i]) begin
            w_commit_arch[i] = rob_arch_i[i];
            w_commit_phys[i] = rob_new_phys_i[i];
            w_free_phys[i]   = rob_old_phys_i[i];
         end
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;
      case (r_state)
         S_RUN: begin
            if (w_mispred) begin
               w_state_nxt     = S_FLUSH;
               w_flush_cnt_nxt = c_FLUSH_LOAD;
            end
         end
         S_FLUSH: begin
            if (r_flush_cnt == 4'd0) begin
               w_state_nxt = S_RUN;
            end else begin
               w_flush_cnt_nxt = r_flush_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt     = S_RUN;
            w_flush_cnt_nxt = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_RUN;
         r_flush_cnt <= 4'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
      end
   end

   // Unretired slots register zeros so an idle edge leaves every output at 0.
   always_ff @(posedge clock) begin
      if (reset) begin
         commit_valid_o <= '0;
         commit_arch_o  <= '0;
         commit_phys_o  <= '0;
         free_valid_o   <= '0;
         free_phys_o    <= '0;
         flush_o        <= 1'b0;
         redirect_pc_o  <= '0;
      end else begin
         commit_valid_o <= w_commit;
         commit_arch_o  <= w_commit_arch;
         commit_phys_o  <= w_commit_phys;
         free_valid_o   <= w_commit;
         free_phys_o    <= w_free_phys;
         flush_o        <= w_mispred;
         redirect_pc_o  <= w_redirect;
      end
   end

`ifdef RETIRE_UNIT_STATS_EN
   logic [31:0] r_retired_cnt;
   logic [31:0] r_mispred_cnt;
   logic [31:0] w_pop;

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         w_pop = w_pop + {31'd0, w_retire[i]};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_retired_cnt <= '0;
         r_mispred_cnt <= '0;
      end else begin
         r_retired_cnt <= r_retired_cnt + w_pop;
         r_mispred_cnt <= r_mispred_cnt + {31'd0, w_mispred};
      end
   end

   assign retired_count_o = r_retired_cnt;
   assign mispred_count_o = r_mispred_cnt;
`else
   assign retired_count_o = '0;
   assign mispred_count_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_retire_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_retire_unit
// Purpose  : Directed and random checks of retire_unit against a slot-count
//            reference model (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_retire_unit;

   localparam int W  = 2;
   localparam int AR = 6;
   localparam int PR = 7;
   localparam int FC = 2;

   logic                   clock;
   logic                   reset;
   logic [W-1:0]           valid, complete, has_dest, mispred;
   logic [W-1:0][AR-1:0]   arch;
   logic [W-1:0][PR-1:0]   newp, oldp;
   logic [W-1:0][31:0]     target;
   logic [W-1:0]           retire_o, commit_valid_o, free_valid_o;
   logic [W-1:0][AR-1:0]   commit_arch_o;
   logic [W-1:0][PR-1:0]   commit_phys_o, free_phys_o;
   logic                   flush_o;
   logic [31:0]            redirect_pc_o, retired_count_o, mispred_count_o;

   int          n_total = 0;
   int          n_bad   = 0;
   int          blk     = 0;
   logic [31:0] m_ret   = 0;
   logic [31:0] m_mis   = 0;

   retire_unit #(
      .ARCH_REGS(64), .PHYS_REGS(128), .COMMIT_WIDTH(W), .FLUSH_CYCLES(FC)
   ) dut (
      .clock(clock), .reset(reset),
      .rob_valid_i(valid), .rob_complete_i(complete),
      .rob_has_dest_i(has_dest), .rob_mispred_i(mispred),
      .rob_arch_i(arch), .rob_new_phys_i(newp), .rob_old_phys_i(oldp),
      .rob_target_i(target), .retire_o(retire_o),
      .commit_valid_o(commit_valid_o), .commit_arch_o(commit_arch_o),
      .commit_phys_o(commit_phys_o), .free_valid_o(free_valid_o),
      .free_phys_o(free_phys_o), .flush_o(flush_o),
      .redirect_pc_o(redirect_pc_o), .retired_count_o(retired_count_o),
      .mispred_count_o(mispred_count_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_counters();
`ifdef RETIRE_UNIT_STATS_EN
      check("retired_cnt", retired_count_o, m_ret);
      check("mispred_cnt", mispred_count_o, m_mis);
`else
      check("retired_cnt", retired_count_o, 0);
      check("mispred_cnt", mispred_count_o, 0);
`endif
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      blk   = 0;
      m_ret = 0;
      m_mis = 0;
      check("rst_commit_v", commit_valid_o, 0);
      check("rst_free_v", free_valid_o, 0);
      check("rst_flush", flush_o, 0);
      check("rst_pc", redirect_pc_o, 0);
      check_counters();
   endtask

   // Model: count how many head slots leave in order, stopping after a
   // mispredict, unless the flush window is still blocking retirement.
   task automatic step();
      int           n;
      logic [W-1:0] exp_ret, exp_cv;
      logic         exp_fl;
      logic [31:0]  exp_pc;
      #1;
      n = 0;
      if (blk == 0) begin
         while (n < W && valid[n] && complete[n]) begin
            n++;
            if (mispred[n-1]) break;
         end
      end
      exp_ret = W'((1 << n) - 1);
      exp_fl  = (n > 0) && mispred[n-1];
      exp_pc  = exp_fl ? target[n-1] : 32'd0;
      for (int i = 0; i < W; i++)
         exp_cv[i] = (i < n) && has_dest[i] && (arch[i] != 0);
      check("retire", retire_o, exp_ret);
      @(posedge clock);
      #1;
      check("commit_v", commit_valid_o, exp_cv);
      check("free_v", free_valid_o, exp_cv);
      for (int i = 0; i < W; i++) begin
         if (exp_cv[i]) begin
            check("commit_arch", commit_arch_o[i], arch[i]);
            check("commit_phys", commit_phys_o[i], newp[i]);
            check("free_phys", free_phys_o[i], oldp[i]);
         end
      end
      if (n == 0) begin
         check("idle_arch", commit_arch_o, 0);
         check("idle_cphys", commit_phys_o, 0);
         check("idle_fphys", free_phys_o, 0);
      end
      check("flush", flush_o, exp_fl);
      check("redirect", redirect_pc_o, exp_pc);
      m_ret = m_ret + n;
      m_mis = m_mis + (exp_fl ? 1 : 0);
      if (exp_fl) blk = FC;
      else if (blk > 0) blk--;
      check_counters();
   endtask

   task automatic set_all(input logic [W-1:0] v, input logic [W-1:0] c,
                          input logic [W-1:0] d, input logic [W-1:0] m);
      valid = v; complete = c; has_dest = d; mispred = m;
   endtask

   task automatic randomize_inputs();
      for (int i = 0; i < W; i++) begin
         valid[i]    = ($urandom % 8) != 0;
         complete[i] = ($urandom % 4) != 0;
         has_dest[i] = ($urandom % 4) != 0;
         mispred[i]  = ($urandom % 6) == 0;
         arch[i]     = (($urandom % 3) == 0) ? AR'($urandom % 4) : AR'($urandom);
         newp[i]     = PR'($urandom);
         oldp[i]     = PR'($urandom);
         target[i]   = $urandom;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      set_all(2'b00, 2'b00, 2'b00, 2'b00);
      arch = '0; newp = '0; oldp = '0; target = '0;
      do_reset();

      // Two plain retires with destinations.
      set_all(2'b11, 2'b11, 2'b11, 2'b00);
      arch[0] = 5; arch[1] = 7; newp[0] = 70; newp[1] = 71; oldp[0] = 5; oldp[1] = 7;
      step();
      // Incomplete head blocks the younger complete slot.
      set_all(2'b11, 2'b10, 2'b11, 2'b00);
      step();
      // Mispredict in slot 0: flush, redirect, two blocked cycles, resume.
      set_all(2'b11, 2'b11, 2'b11, 2'b01);
      target[0] = 32'h1000;
      step();
      set_all(2'b11, 2'b11, 2'b11, 2'b00);
      step();
      check("flush_window", retire_o, 2'b00);
      step();
      step();
      check("resume", commit_valid_o, 2'b11);
      // Same architectural register in both slots; then arch 0 in slot 1.
      arch[0] = 3; arch[1] = 3; newp[0] = 40; newp[1] = 41;
      step();
      check("same_reg_slot1", commit_phys_o[1], 41);
      arch[1] = 0;
      step();
      // Reset during the first flush cycle aborts the flush.
      set_all(2'b11, 2'b11, 2'b11, 2'b01);
      step();
      set_all(2'b11, 2'b11, 2'b11, 2'b00);
      arch[1] = 9;
      do_reset();
      step();
      check("post_rst_flush", flush_o, 0);
      // Statistics: three edges of two retires, one of them mispredicted.
      do_reset();
      step();
      step();
      set_all(2'b11, 2'b11, 2'b11, 2'b10);
      step();
`ifdef RETIRE_UNIT_STATS_EN
      check("stats_ret6", retired_count_o, 6);
      check("stats_mis1", mispred_count_o, 1);
`else
      check("stats_ret0", retired_count_o, 0);
      check("stats_mis0", mispred_count_o, 0);
`endif

      for (int k = 0; k < 500; k++) begin
         randomize_inputs();
         if (($urandom % 60) == 0) do_reset();
         else step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
